// File: rtl/mem1r1w_fifo_ctrl_pkg.sv
// Shared sizing for the 1R1W FIFO controller and the memory wrapper that
// sits next to it in the parent. Widths are derived from DEPTH only.
package mem1r1w_pkg;

    localparam int DEF_WIDTH = 32'd64;
    localparam int DEF_DEPTH = 32'd32;

    // Address width of a DEPTH-entry memory (DEPTH is a power of two).
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of the occupancy count, which spans 0..DEPTH+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 32'd2);
    endfunction

endpackage : mem1r1w_pkg

// File: rtl/mem1r1w_fifo_ctrl_if.sv
// Producer/consumer handshakes plus the memory macro port of the FIFO
// controller. The master side is the controller, the slave side is the
// surrounding logic (producer, consumer and memory), mon observes everything.
interface mem1r1w_fifo_ctrl_if
    import mem1r1w_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    modport master (
        input  flush, in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, count,
               mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

    modport slave (
        output flush, in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, count,
               mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

    modport mon (
        input flush, in_valid, in_data, out_ready, mem_rdata,
              in_ready, out_valid, out_data, count,
              mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

endinterface : mem1r1w_fifo_ctrl_if

// File: rtl/mem1r1w_fifo_ctrl_chk.sv
// Property checker for the FIFO controller, observing only its ports.
// Memory occupancy is recovered as count minus the output register.
module mem1r1w_fifo_ctrl_chk
    import mem1r1w_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic               clock,
    input logic               reset,
    mem1r1w_fifo_ctrl_if.mon  bus
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [CNT_W-1:0] mem_cnt_s;
    logic             load_s;

    assign mem_cnt_s = bus.count - CNT_W'(bus.out_valid);
    assign load_s    = ~bus.out_valid | bus.out_ready;

    // A memory word that is consumed this cycle is never the one being written.
    a_no_read_under_write: assert property (@(posedge clock) disable iff (!reset)
        !(load_s && (mem_cnt_s != {CNT_W{1'b0}}) && bus.mem_wen &&
          (bus.mem_waddr == bus.mem_raddr)));

    // Occupancy never exceeds memory plus the output register.
    a_count_bound: assert property (@(posedge clock) disable iff (!reset)
        bus.count <= CNT_W'(DEPTH + 1));

    // Flush blocks new data and memory writes in the same cycle.
    a_flush_quiet: assert property (@(posedge clock) disable iff (!reset)
        bus.flush |-> (!bus.in_ready && !bus.mem_wen));

endmodule : mem1r1w_fifo_ctrl_chk

// File: rtl/mem1r1w_fifo_ctrl_wrap_ptr.sv
// Wrapping address pointer: counts up on inc, returns to zero on clr.
// Wrap from DEPTH-1 to 0 comes from the natural ADDR_W overflow.
module wrap_ptr #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register; clear has priority over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + ADDR_W'(1'b1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule : wrap_ptr

// File: rtl/mem1r1w_fifo_ctrl.sv
// FIFO controller driving an external DEPTH x WIDTH 1R1W memory (combinational
// read) with one output holding register in front of the consumer, for a total
// capacity of DEPTH+1. A push that finds the memory empty and the output
// register free goes straight into the output register and skips the memory.
module mem1r1w_fifo_ctrl
    import mem1r1w_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic                  clock,
    input logic                  reset,
    mem1r1w_fifo_ctrl_if.master  bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(DEPTH);

    // Registered state
    logic [CNT_W-1:0]  mem_cnt_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;

    // Next-state values
    logic [CNT_W-1:0]  mem_cnt_nxt_s;
    logic              out_valid_nxt_s;
    logic [WIDTH-1:0]  out_data_nxt_s;

    // Pointers
    logic [ADDR_W-1:0] rd_ptr_s;
    logic [ADDR_W-1:0] wr_ptr_s;

    // Handshake decode
    logic in_ready_s;
    logic push_s;
    logic pop_s;
    logic load_s;
    logic mem_avail_s;
    logic take_mem_s;
    logic bypass_s;
    logic mem_write_s;
    logic rd_inc_s;

    // Handshake decode; in_ready depends on registered state and flush only,
    // so there is no path from out_ready to in_ready.
    always_comb begin
        in_ready_s  = (mem_cnt_r != MEM_FULL) & ~bus.flush;
        push_s      = bus.in_valid & in_ready_s;
        pop_s       = out_valid_r & bus.out_ready;
        load_s      = ~out_valid_r | pop_s;
        mem_avail_s = (mem_cnt_r != CNT_ZERO);
        take_mem_s  = load_s & mem_avail_s;
        bypass_s    = load_s & ~mem_avail_s & push_s;
        // Write enable is forced low while reset is held.
        mem_write_s = push_s & ~bypass_s & reset;
        rd_inc_s    = take_mem_s & ~bus.flush;
    end

    // Next state of memory occupancy and the output holding register.
    always_comb begin
        mem_cnt_nxt_s   = mem_cnt_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        if (bus.flush) begin
            // Contents are discarded; the last output word is left in place.
            mem_cnt_nxt_s   = CNT_ZERO;
            out_valid_nxt_s = 1'b0;
        end else begin
            case ({mem_write_s, take_mem_s})
                2'b10:   mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
                2'b01:   mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
                default: mem_cnt_nxt_s = mem_cnt_r;
            endcase

            if (take_mem_s) begin
                // Refill from the memory head word.
                out_data_nxt_s  = bus.mem_rdata;
                out_valid_nxt_s = 1'b1;
            end else if (bypass_s) begin
                // Memory empty: the incoming word goes straight to the output.
                out_data_nxt_s  = bus.in_data;
                out_valid_nxt_s = 1'b1;
            end else if (load_s) begin
                // Nothing to load: the register empties if it was popped.
                out_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = out_valid_r;
            end
        end
    end

    // State registers for occupancy and the output holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_cnt_r   <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            mem_cnt_r   <= mem_cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    wrap_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (rd_inc_s),
        .ptr   (rd_ptr_s)
    );

    wrap_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (mem_write_s),
        .ptr   (wr_ptr_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.count     = mem_cnt_r + CNT_W'(out_valid_r);
    assign bus.mem_raddr = rd_ptr_s;
    assign bus.mem_wen   = mem_write_s;
    assign bus.mem_waddr = wr_ptr_s;
    assign bus.mem_wdata = bus.in_data;

endmodule : mem1r1w_fifo_ctrl

// File: tb/tb_mem1r1w_fifo_ctrl.sv
// Bench for mem1r1w_fifo_ctrl: a 1R1W memory model returning X on
// read-under-write, a queue-based reference of the whole FIFO, a short
// table of hand-derived vectors and directed/random sequences.
module tb_mem1r1w_fifo_ctrl;
    localparam int WIDTH = 64;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mem1r1w_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mem1r1w_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    mem1r1w_fifo_ctrl_chk #(.WIDTH(WIDTH), .DEPTH(DEPTH)) chk_i (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural 1R1W memory
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = (bus.mem_wen && (bus.mem_waddr == bus.mem_raddr)) ?
                           {WIDTH{1'bx}} : mem[bus.mem_raddr];

    int n_vec = 0;
    int n_err = 0;

    // Reference: everything held, head first
    logic [WIDTH-1:0] q[$];
    bit               m_push, m_pop, m_flush;
    logic [WIDTH-1:0] m_data;

    typedef struct {
        bit               iv;
        bit               ordy;
        bit               fl;
        logic [WIDTH-1:0] d;
        bit               e_ir;
        bit               e_ov;
        int               e_cnt;
        logic [WIDTH-1:0] e_od;
        bit               e_wen;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // Compare DUT outputs with the reference before the edge.
    task automatic model_check();
        int sz;
        bit e_ir, e_ov, e_wen;
        sz      = q.size();
        e_ir    = (sz <= DEPTH) && !bus.flush;
        e_ov    = (sz != 0);
        m_push  = bus.in_valid && e_ir;
        m_pop   = e_ov && bus.out_ready;
        m_flush = bus.flush;
        m_data  = bus.in_data;
        // Only a word arriving into an otherwise empty FIFO skips memory.
        e_wen   = m_push && !((sz == 0) || (sz == 1 && m_pop));
        chk("in_ready",  64'(bus.in_ready),  64'(e_ir));
        chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
        chk("count",     64'(bus.count),     64'(sz));
        chk("mem_wen",   64'(bus.mem_wen),   64'(e_wen));
        if (e_ov) chk("out_data", bus.out_data, q[0]);
    endtask

    task automatic model_update();
        if (m_flush) begin
            q.delete();
        end else begin
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_data);
        end
    endtask

    task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        drive(iv, d, ordy, fl);
        @(negedge clock);
        model_check();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drained", 64'(bus.count), 64'h0);
    endtask

    initial begin
        //                 iv    ordy  fl    data    ir    ov    cnt  out_data wen
        tbl[0] = '{1'b1, 1'b0, 1'b0, 64'hA5, 1'b1, 1'b0, 0, 64'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 1, 64'hA5, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 64'h11, 1'b1, 1'b1, 1, 64'hA5, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 64'h22, 1'b1, 1'b1, 2, 64'hA5, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 64'h00, 1'b1, 1'b1, 2, 64'h11, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 64'h00, 1'b1, 1'b1, 1, 64'h22, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 64'h33, 1'b1, 1'b0, 0, 64'h22, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 64'h00, 1'b0, 1'b1, 1, 64'h33, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 0, 64'h33, 1'b0};

        // Reset state, with a push attempt held during reset
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        #1;
        chk("rst_mem_wen",   64'(bus.mem_wen),   64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_count",     64'(bus.count),     64'h0);
        chk("rst_out_data",  bus.out_data,       64'h0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Table: bypass latency, refill, empty+push+out_ready, flush
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            @(negedge clock);
            chk("tbl_in_ready",  64'(bus.in_ready),  64'(tbl[i].e_ir));
            chk("tbl_out_valid", 64'(bus.out_valid), 64'(tbl[i].e_ov));
            chk("tbl_count",     64'(bus.count),     64'(tbl[i].e_cnt));
            chk("tbl_out_data",  bus.out_data,       tbl[i].e_od);
            chk("tbl_mem_wen",   64'(bus.mem_wen),   64'(tbl[i].e_wen));
            model_check();
            @(posedge clock);
            model_update();
            #1;
        end

        // Fill to capacity with 1..33, then push+pop at full
        for (int i = 1; i <= 33; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
        chk("full_count",    64'(bus.count),    64'd33);
        chk("full_in_ready", 64'(bus.in_ready), 64'h0);
        cycle(1'b1, 64'd99, 1'b1, 1'b0);
        chk("refill_head",   bus.out_data,      64'd2);
        chk("ready_returns", 64'(bus.in_ready), 64'h1);
        cycle(1'b1, 64'd100, 1'b1, 1'b0);
        for (int i = 3; i <= 33; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            #1;
            chk("drain_order", bus.out_data, 64'(i));
            cycle(1'b0, 64'h0, 1'b1, 1'b0);
        end
        drain();

        // Steady stream 0..99 at one word per cycle
        for (int i = 0; i < 100; i++) begin
            if (i > 0) chk("stream_count", 64'(bus.count), 64'h1);
            cycle(1'b1, 64'(i), 1'b1, 1'b0);
        end
        drain();

        // Random push/pop across the pointer wrap
        for (int i = 0; i < 300; i++) begin
            bit iv, ordy;
            iv   = (i < 150) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 40);
            ordy = (i < 150) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 70);
            cycle(iv, {$urandom, $urandom}, ordy, 1'b0);
        end
        drain();

        // Flush at count 10 with a pop and a push attempt in the flush cycle
        for (int i = 0; i < 10; i++) cycle(1'b1, 64'(16'hF00 + i), 1'b0, 1'b0);
        chk("pre_flush_count", 64'(bus.count), 64'd10);
        cycle(1'b1, 64'hDEAD, 1'b1, 1'b1);
        chk("post_flush_count", 64'(bus.count),     64'h0);
        chk("post_flush_valid", 64'(bus.out_valid), 64'h0);

        // Async reset in the middle of a stream
        for (int i = 0; i < 6; i++) cycle(1'b1, 64'(16'hB00 + i), (i > 2), 1'b0);
        drive(1'b1, 64'hBEEF, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count",     64'(bus.count),     64'h0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("arst_mem_wen",   64'(bus.mem_wen),   64'h0);
        q.delete();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b1, 64'h7, 1'b0, 1'b0);
        cycle(1'b1, 64'h8, 1'b0, 1'b0);
        chk("first_after_reset", bus.out_data, 64'h7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem1r1w_fifo_ctrl
